// File: rtl/modulo_pkg.sv
// Shared definitions for the sequential modulo/divide unit.
//   MODULO_WIDTH   : default operand/result width
//   modulo_state_t : controller states (IDLE -> CALC -> DONE -> IDLE)
package modulo_pkg;

  localparam int unsigned MODULO_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } modulo_state_t;

endpackage

// File: rtl/modulo_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_i     : current partial remainder (always < divisor)
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor
//   rem_o     : new partial remainder
//   q_o       : quotient bit produced by this step
module modulo_step
  import modulo_pkg::*;
#(
  parameter int unsigned WIDTH = MODULO_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] trial_lo;

  // The trial keeps the full remainder plus the new bit (WIDTH+1 bits), so
  // the compare never overflows even for divisors with the MSB set. The
  // subtraction result is always < divisor, so the low WIDTH bits suffice.
  always_comb begin
    trial    = {rem_i, bit_i};
    trial_lo = trial[WIDTH-1:0];
    q_o      = (trial >= {1'b0, divisor_i});
    rem_o    = q_o ? (trial_lo - divisor_i) : trial_lo;
  end

endmodule

// File: rtl/modulo_div_seq.sv
// Sequential restoring divider: remainder and floor quotient of two unsigned
// WIDTH-bit operands, one quotient bit per clock, with divide-by-zero flag.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start_i    : request, accepted only while idle
//   Zahl1_i    : dividend, sampled on the accepting edge
//   Zahl2_i    : divisor, sampled on the accepting edge
//   busy_o     : high from the accepting edge until valid_o deasserts
//   valid_o    : one-cycle result strobe
//   ergebnis_o : remainder Zahl1 mod Zahl2 (Zahl1 on divide by zero)
//   quotient_o : Zahl1 / Zahl2 (all ones on divide by zero)
//   div_zero_o : set with the result when the divisor was zero
// Build option:
//   MODULO_EARLY_EXIT_EN : when defined, a nonzero divisor larger than the
//   dividend finishes in one cycle instead of WIDTH (same result values).
module modulo_div_seq
  import modulo_pkg::*;
#(
  parameter int unsigned WIDTH = MODULO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] ergebnis_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic             div_zero_o
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  modulo_state_t state_q, state_d;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             div_by_zero;
  logic             early_exit;
  logic             last_step;

  assign div_by_zero = (Zahl2_i == '0);

`ifdef MODULO_EARLY_EXIT_EN
  assign early_exit = !div_by_zero && (Zahl1_i < Zahl2_i);
`else
  assign early_exit = 1'b0;
`endif

  // Counter reaches zero on the edge that performs this step.
  assign last_step = (cnt_q == CNT_ONE);

  modulo_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .bit_i    (shift_q[WIDTH-1]),
    .divisor_i(divisor_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = (div_by_zero || early_exit) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy_o  = (state_q != IDLE);
    valid_o = (state_q == DONE);
  end

  // Datapath: operand capture, iteration, and result registers. The shift
  // register serves both as dividend source (MSB out) and quotient sink (LSB in).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q      <= '0;
      shift_q    <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      ergebnis_o <= '0;
      quotient_o <= '0;
      div_zero_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            divisor_q <= Zahl2_i;
            shift_q   <= Zahl1_i;
            rem_q     <= '0;
            cnt_q     <= CNT_LOAD;
            if (div_by_zero) begin
              ergebnis_o <= Zahl1_i;
              quotient_o <= '1;
              div_zero_o <= 1'b1;
            end else if (early_exit) begin
              ergebnis_o <= Zahl1_i;
              quotient_o <= '0;
              div_zero_o <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_q   <= step_rem;
          shift_q <= {shift_q[WIDTH-2:0], step_q};
          cnt_q   <= cnt_q - CNT_ONE;
          if (last_step) begin
            ergebnis_o <= step_rem;
            quotient_o <= {shift_q[WIDTH-2:0], step_q};
            div_zero_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_div_seq.sv
// Self-checking bench for modulo_div_seq: one WIDTH=16 and one WIDTH=8
// instance, directed and random operands against an arithmetic reference.
module tb_modulo_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        st16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, valid16, dz16;
  logic [15:0] r16, q16;

  logic        st8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, valid8, dz8;
  logic [7:0]  r8, q8;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modulo_div_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (st16),
    .Zahl1_i   (a16),
    .Zahl2_i   (b16),
    .busy_o    (busy16),
    .valid_o   (valid16),
    .ergebnis_o(r16),
    .quotient_o(q16),
    .div_zero_o(dz16)
  );

  modulo_div_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (st8),
    .Zahl1_i   (a8),
    .Zahl2_i   (b8),
    .busy_o    (busy8),
    .valid_o   (valid8),
    .ergebnis_o(r8),
    .quotient_o(q8),
    .div_zero_o(dz8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One operation on the selected instance, checked against plain arithmetic.
  task automatic run_op(input bit w8, input logic [15:0] a_in, input logic [15:0] b_in);
    int unsigned w, acc, exp_lat;
    logic [15:0] mask, a, b, er, eq;
    logic        edz;
    bit          seen;
    string       p;
    w    = w8 ? 8 : 16;
    mask = w8 ? 16'h00FF : 16'hFFFF;
    a    = a_in & mask;
    b    = b_in & mask;
    p    = $sformatf("w%0d %0d/%0d", w, a, b);
    if (b == 16'd0) begin
      er = a; eq = mask; edz = 1'b1;
    end else begin
      er = a % b; eq = a / b; edz = 1'b0;
    end
    exp_lat = (b == 16'd0) ? 0 : w;
`ifdef MODULO_EARLY_EXIT_EN
    if (b != 16'd0 && a < b) exp_lat = 0;
`endif
    @(negedge clk);
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; st8 = 1'b1; end
    else    begin a16 = a;     b16 = b;     st16 = 1'b1; end
    @(negedge clk);
    acc = cyc;
    // Operands scrambled after acceptance must not matter.
    if (w8) begin st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); end
    else    begin st16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); end
    check({p, " busy_after_accept"}, 32'(w8 ? busy8 : busy16), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((w8 ? valid8 : valid16) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({p, " valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({p, " latency"}, cyc - acc, exp_lat);
      check({p, " rem"}, 32'(w8 ? {8'h00, r8} : r16), 32'(er));
      check({p, " quot"}, 32'(w8 ? {8'h00, q8} : q16), 32'(eq));
      check({p, " dz"}, 32'(w8 ? dz8 : dz16), 32'(edz));
      check({p, " busy_at_valid"}, 32'(w8 ? busy8 : busy16), 32'd1);
      @(negedge clk);
      check({p, " valid_one_cycle"}, 32'(w8 ? valid8 : valid16), 32'd0);
      check({p, " busy_cleared"}, 32'(w8 ? busy8 : busy16), 32'd0);
      check({p, " rem_hold"}, 32'(w8 ? {8'h00, r8} : r16), 32'(er));
    end
  endtask

  initial begin : main
    int unsigned rises[3];
    int          nrise, lowcnt, cls;
    int unsigned rel;
    bit          prev, seen;
    logic [15:0] ra, rb;

    // Reset state
    #1;
    check("rst busy16", 32'(busy16), 32'd0);
    check("rst valid16", 32'(valid16), 32'd0);
    check("rst rem16", 32'(r16), 32'd0);
    check("rst quot16", 32'(q16), 32'd0);
    check("rst dz16", 32'(dz16), 32'd0);
    check("rst valid8", 32'(valid8), 32'd0);
    check("rst quot8", 32'(q8), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors, WIDTH=16
    run_op(1'b0, 16'd400, 16'd20);
    run_op(1'b0, 16'd9540, 16'd5175);
    run_op(1'b0, 16'd65535, 16'd1);
    run_op(1'b0, 16'd7, 16'd300);
    run_op(1'b0, 16'd123, 16'd0);
    run_op(1'b0, 16'd65535, 16'd65535);
    run_op(1'b0, 16'd65534, 16'd65535);
    run_op(1'b0, 16'd65535, 16'd40000);
    run_op(1'b0, 16'd0, 16'd0);
    run_op(1'b0, 16'd0, 16'd5);

    // Back-to-back with start held, then reset in the middle of a calculation
    @(negedge clk);
    a16 = 16'd400; b16 = 16'd20; st16 = 1'b1;
    nrise = 0; lowcnt = 0; prev = 1'b0;
    for (int i = 0; i < 200 && nrise < 3; i++) begin
      @(negedge clk);
      if (valid16 && !prev) begin
        rises[nrise] = cyc;
        nrise++;
        check("b2b rem", 32'(r16), 32'd0);
        check("b2b quot", 32'(q16), 32'd20);
        if (nrise == 2) check("b2b idle_gap", lowcnt, 32'd1);
      end
      if (nrise >= 1 && !busy16) lowcnt++;
      prev = valid16;
    end
    check("b2b three_results", 32'(nrise), 32'd3);
    if (nrise == 3) begin
      check("b2b period1", rises[1] - rises[0], 32'd18);
      check("b2b period2", rises[2] - rises[1], 32'd18);
      // Third op is accepted two edges after its predecessor's DONE entry.
      for (int i = 0; i < 100 && cyc < rises[2] + 10; i++) @(negedge clk);
      check("abort in_calc", 32'(busy16), 32'd1);
      rst = 1'b0;
      #1;
      check("abort busy", 32'(busy16), 32'd0);
      check("abort valid", 32'(valid16), 32'd0);
      check("abort rem", 32'(r16), 32'd0);
      check("abort quot", 32'(q16), 32'd0);
      check("abort dz", 32'(dz16), 32'd0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      rel = cyc;
      @(negedge clk);
      check("restart accepted", 32'(busy16), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (valid16 === 1'b1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("restart valid_seen", 32'(seen), 32'd1);
      check("restart latency", cyc - rel, 32'd17);
      check("restart quot", 32'(q16), 32'd20);
      check("restart rem", 32'(r16), 32'd0);
    end
    st16 = 1'b0;

    // Random operands, WIDTH=16, biased towards boundary classes
    for (int n = 0; n < 25; n++) begin
      cls = int'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      case (cls)
        0: rb = 16'd0;
        1: rb = 16'd1;
        2: if (rb != 16'd0) ra = ra % rb;
        3: rb = 16'($urandom_range(1, 255));
        default: ;
      endcase
      run_op(1'b0, ra, rb);
    end

    // WIDTH=8 instance
    run_op(1'b1, 16'd200, 16'd7);
    run_op(1'b1, 16'd5, 16'd0);
    run_op(1'b1, 16'd255, 16'd255);
    run_op(1'b1, 16'd255, 16'd1);
    run_op(1'b1, 16'd3, 16'd200);
    for (int n = 0; n < 10; n++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      run_op(1'b1, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
